// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the handshaked sequential ALU.
//   Op codes (4-bit, op[2:0] compatible with the single-cycle ALU),
//   FSM state encoding and the is_multicycle() helper.
//   Optional feature macro: ALU_SEQ_DIV_EN (enables DIVU as a multicycle op).
package alu_seq_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MULU = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1010;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'b00;
   localparam state_t ST_BUSY = 2'b01;
   localparam state_t ST_DONE = 2'b10;

   // True for ops that run through the iterative multiply/divide unit.
   function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
      return (op == OP_MULU) || (op == OP_DIVU);
`else
      return (op == OP_MULU);
`endif
   endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv -- iterative unsigned multiply (shift-add) and restoring
// divide sharing one shift register pair, one adder and one counter.
//   clk, reset_n      : clock, async active-low reset
//   start             : load operands and begin WIDTH iterations
//   div_sel           : 1 = divide, 0 = multiply (sampled with start)
//   a, b              : multiplicand/dividend, multiplier/divisor
//   done              : this cycle's edge performs the final iteration
//   lo_next, hi_next  : register values after this cycle's iteration
//                       (product low/high, or quotient/remainder)
//   Macro ALU_SEQ_DIV_EN is handled by the top; with it undefined div_sel
//   is tied low and the divide path is constant-folded away.
module alu_seq_muldiv
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNTW  = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             div_sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo_next,
   output logic [WIDTH-1:0] hi_next
);

   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             div_q, div_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;

   logic [WIDTH:0]   shifted_s;
   logic [WIDTH+1:0] base_s;
   logic [WIDTH+1:0] addend_s;
   logic             cin_s;
   logic [WIDTH+1:0] sum_s;
   logic             fits_s;
   logic [WIDTH-1:0] lo_nxt_s;
   logic [WIDTH-1:0] hi_nxt_s;

   // Divide: partial remainder shifted left with the next dividend bit.
   assign shifted_s = {hi_q, lo_q[WIDTH-1]};

   // Select adder operands: add multiplicand, or subtract divisor (~x + 1).
   always_comb begin
      if (div_q) begin
         base_s   = {1'b0, shifted_s};
         addend_s = ~{2'b00, opnd_q};
         cin_s    = 1'b1;
      end else begin
         base_s   = {2'b00, hi_q};
         addend_s = lo_q[0] ? {2'b00, opnd_q} : {(WIDTH+2){1'b0}};
         cin_s    = 1'b0;
      end
   end

   assign sum_s = base_s + addend_s + {{(WIDTH+1){1'b0}}, cin_s};

   // One iteration: restoring-subtract step or shift-add step.
   always_comb begin
      fits_s = 1'b0;
      if (div_q) begin
         // Top bit of the extended difference is the borrow: set means restore.
         fits_s   = ~sum_s[WIDTH+1];
         hi_nxt_s = fits_s ? sum_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
         lo_nxt_s = {lo_q[WIDTH-2:0], fits_s};
      end else begin
         hi_nxt_s = sum_s[WIDTH:1];
         lo_nxt_s = {sum_s[0], lo_q[WIDTH-1:1]};
      end
   end

   // Next-state for the counter and shift registers.
   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      lo_d   = lo_q;
      hi_d   = hi_q;
      opnd_d = opnd_q;
      if (start) begin
         cnt_d  = CNTW'(WIDTH);
         div_d  = div_sel;
         lo_d   = a;
         hi_d   = {WIDTH{1'b0}};
         opnd_d = b;
      end else if (cnt_q != {CNTW{1'b0}}) begin
         cnt_d = cnt_q - {{(CNTW-1){1'b0}}, 1'b1};
         lo_d  = lo_nxt_s;
         hi_d  = hi_nxt_s;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= {CNTW{1'b0}};
         div_q  <= 1'b0;
         lo_q   <= {WIDTH{1'b0}};
         hi_q   <= {WIDTH{1'b0}};
         opnd_q <= {WIDTH{1'b0}};
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         lo_q   <= lo_d;
         hi_q   <= hi_d;
         opnd_q <= opnd_d;
      end
   end

   assign done    = (cnt_q == {{(CNTW-1){1'b0}}, 1'b1});
   assign lo_next = lo_nxt_s;
   assign hi_next = hi_nxt_s;

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- parametrised sequential ALU with valid/ready handshake.
//   in_valid/in_ready : operation handshake (op, a, b captured on accept)
//   out_valid/out_ready : result handshake; outputs held until taken
//   result, hi        : primary result / high product or remainder
//   zero, ovf, err    : result==0, signed ADD/SUB overflow, illegal op or /0
//   Single-cycle ops: latency 1. MULU (and DIVU with ALU_SEQ_DIV_EN defined):
//   WIDTH+1. With ALU_SEQ_DIV_EN undefined, DIVU is an illegal op.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNTW  = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             ovf,
   output logic             err
);

   state_t           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;
   logic             div_err_q, div_err_d;

   logic             sub_s;
   logic [WIDTH-1:0] b_op_s;
   logic [WIDTH:0]   full_s;
   logic             cout_s;
   logic             c_msb_s;
   logic             add_ovf_s;
   logic             slt_s;
   logic [WIDTH-1:0] sc_result_s;
   logic             sc_ovf_s;
   logic             sc_err_s;

   logic             md_start_s;
   logic             md_div_s;
   logic             md_done_s;
   logic [WIDTH-1:0] md_lo_s;
   logic [WIDTH-1:0] md_hi_s;

   // Shared adder: SUB/SLT/SLTU use a + ~b + 1.
   assign sub_s   = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
   assign b_op_s  = sub_s ? ~b : b;
   assign full_s  = {1'b0, a} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, sub_s};
   assign cout_s  = full_s[WIDTH];
   // Carry into the MSB recovered from the MSB sum bit and its operands.
   assign c_msb_s   = full_s[WIDTH-1] ^ a[WIDTH-1] ^ b_op_s[WIDTH-1];
   assign add_ovf_s = c_msb_s ^ cout_s;
   assign slt_s     = full_s[WIDTH-1] ^ add_ovf_s;

   // Single-cycle result, overflow and illegal-op detection.
   always_comb begin
      sc_result_s = {WIDTH{1'b0}};
      sc_ovf_s    = 1'b0;
      sc_err_s    = 1'b0;
      case (op)
         OP_AND:  sc_result_s = a & b;
         OP_OR:   sc_result_s = a | b;
         OP_XOR:  sc_result_s = a ^ b;
         OP_NOR:  sc_result_s = ~(a | b);
         OP_ADD: begin
            sc_result_s = full_s[WIDTH-1:0];
            sc_ovf_s    = add_ovf_s;
         end
         OP_SUB: begin
            sc_result_s = full_s[WIDTH-1:0];
            sc_ovf_s    = add_ovf_s;
         end
         OP_SLT:  sc_result_s = {{(WIDTH-1){1'b0}}, slt_s};
         OP_SLTU: sc_result_s = {{(WIDTH-1){1'b0}}, ~cout_s};
         OP_MULU: sc_err_s    = 1'b0;
`ifdef ALU_SEQ_DIV_EN
         OP_DIVU: sc_err_s    = 1'b0;
`endif
         default: sc_err_s    = 1'b1;
      endcase
   end

   assign md_start_s = (state_q == ST_IDLE) && in_valid && is_multicycle(op);
`ifdef ALU_SEQ_DIV_EN
   assign md_div_s   = (op == OP_DIVU);
`else
   assign md_div_s   = 1'b0;
`endif

   alu_seq_muldiv #(
      .WIDTH (WIDTH),
      .CNTW  (CNTW)
   ) u_muldiv (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (md_start_s),
      .div_sel (md_div_s),
      .a       (a),
      .b       (b),
      .done    (md_done_s),
      .lo_next (md_lo_s),
      .hi_next (md_hi_s)
   );

   // Control FSM and output register next-state.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      hi_d        = hi_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      err_d       = err_q;
      div_err_d   = div_err_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && is_multicycle(op)) begin
               state_d   = ST_BUSY;
               div_err_d = md_div_s && (b == {WIDTH{1'b0}});
            end else if (in_valid) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               result_d    = sc_result_s;
               hi_d        = {WIDTH{1'b0}};
               zero_d      = (sc_result_s == {WIDTH{1'b0}});
               ovf_d       = sc_ovf_s;
               err_d       = sc_err_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // Final iteration lands directly in the output registers.
            if (md_done_s) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               result_d    = md_lo_s;
               hi_d        = md_hi_s;
               zero_d      = (md_lo_s == {WIDTH{1'b0}});
               ovf_d       = 1'b0;
               err_d       = div_err_q;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // FSM and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= {WIDTH{1'b0}};
         hi_q        <= {WIDTH{1'b0}};
         zero_q      <= 1'b1;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
         div_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         hi_q        <= hi_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
         div_err_q   <= div_err_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign hi        = hi_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;
   assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- table-driven self-checking bench for alu_seq (WIDTH=32),
// plus hand sequences for backpressure, reset during MULU and stray out_ready.
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W = 32;

   logic         clk;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [W-1:0] hi;
   logic         zero;
   logic         ovf;
   logic         err;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      int           id;
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         z;
      logic         o;
      logic         e;
      int           lat;
   } vec_t;

   vec_t vecs[$];

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .hi        (hi),
      .zero      (zero),
      .ovf       (ovf),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one op, measure latency, check outputs, then take the result.
   task automatic run_vec(input vec_t v);
      int lat;
      logic seen;
      logic leak;
      @(negedge clk);
      chk($sformatf("v%0d in_ready_idle", v.id), {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      op = v.op;
      a = v.a;
      b = v.b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      seen = out_valid;
      leak = 1'b0;
      while (!seen && lat < 40) begin
         if (in_ready) leak = 1'b1;
         @(posedge clk);
         #1;
         lat++;
         seen = out_valid;
      end
      chk($sformatf("v%0d latency", v.id), lat, v.lat);
      chk($sformatf("v%0d in_ready_busy", v.id), {31'd0, leak}, 32'd0);
      chk($sformatf("v%0d result", v.id), result, v.res);
      chk($sformatf("v%0d hi", v.id), hi, v.hi);
      chk($sformatf("v%0d zero", v.id), {31'd0, zero}, {31'd0, v.z});
      chk($sformatf("v%0d ovf", v.id), {31'd0, ovf}, {31'd0, v.o});
      chk($sformatf("v%0d err", v.id), {31'd0, err}, {31'd0, v.e});
      chk($sformatf("v%0d in_ready_done", v.id), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk($sformatf("v%0d out_valid_taken", v.id), {31'd0, out_valid}, 32'd0);
      chk($sformatf("v%0d in_ready_back", v.id), {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = 4'b0000;
      a         = 32'd0;
      b         = 32'd0;

      //            id  op        a             b             result        hi            z     o     e     lat
      vecs.push_back('{ 1, OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1});
      vecs.push_back('{ 2, OP_SUB,  32'd5,         32'd5,         32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{ 3, OP_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{ 4, OP_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{ 5, OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'h0, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{ 6, OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 32'h0, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{ 7, OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 32'h0, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{ 8, OP_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{ 9, OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{10, OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1});
      vecs.push_back('{11, OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{12, OP_ADD,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1});
      vecs.push_back('{13, OP_SLT,  32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{14, OP_SLT,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{15, OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back('{16, OP_SLTU, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back('{17, OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 33});
      vecs.push_back('{18, OP_MULU, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 33});
      vecs.push_back('{19, OP_MULU, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 33});
`ifdef ALU_SEQ_DIV_EN
      vecs.push_back('{20, OP_DIVU, 32'd100,       32'd7,         32'd14,        32'd2,        1'b0, 1'b0, 1'b0, 33});
      vecs.push_back('{21, OP_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF, 32'd9,        1'b0, 1'b0, 1'b1, 33});
      vecs.push_back('{22, OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 33});
`else
      vecs.push_back('{20, OP_DIVU, 32'd100,       32'd7,         32'h0,         32'h0,        1'b1, 1'b0, 1'b1, 1});
      vecs.push_back('{21, OP_DIVU, 32'd9,         32'd0,         32'h0,         32'h0,        1'b1, 1'b0, 1'b1, 1});
`endif
      vecs.push_back('{23, 4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0,         32'h0,        1'b1, 1'b0, 1'b1, 1});
      vecs.push_back('{24, 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0,        1'b1, 1'b0, 1'b1, 1});

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst result", result, 32'd0);
      chk("rst hi", hi, 32'd0);
      chk("rst zero", {31'd0, zero}, 32'd1);
      chk("rst ovf", {31'd0, ovf}, 32'd0);
      chk("rst err", {31'd0, err}, 32'd0);
      reset_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // out_ready while nothing is valid has no effect.
      @(negedge clk);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("stray out_ready out_valid", {31'd0, out_valid}, 32'd0);
      chk("stray out_ready in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b0;

      // Backpressure: OR result held for 5 cycles while a new ADD waits.
      @(negedge clk);
      in_valid = 1'b1;
      op = OP_OR;
      a = 32'd1;
      b = 32'd2;
      @(posedge clk);
      #1;
      op = OP_ADD;
      a = 32'd10;
      b = 32'd20;
      chk("bp first out_valid", {31'd0, out_valid}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d result", k), result, 32'd3);
         chk($sformatf("bp%0d out_valid", k), {31'd0, out_valid}, 32'd1);
         chk($sformatf("bp%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp release out_valid", {31'd0, out_valid}, 32'd0);
      chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp next out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp next result", result, 32'd30);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Reset asserted at cycle 10 of a MULU.
      @(negedge clk);
      in_valid = 1'b1;
      op = OP_MULU;
      a = 32'hFFFF_FFFF;
      b = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("midrst busy in_ready", {31'd0, in_ready}, 32'd0);
      reset_n = 1'b0;
      #1;
      chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst result", result, 32'd0);
      chk("midrst zero", {31'd0, zero}, 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      run_vec('{30, 4'b1111, 32'h0000_0005, 32'h0000_0003, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle ALU, for the multicycle datapath.
- Keeps the 3-bit op encoding in op[2:0] for compatibility.
- Adds XOR, NOR, SLTU, signed overflow, a zero flag, an iterative unsigned multiply and an iterative unsigned divide.
- Every result is registered and delivered over a valid/ready handshake, so the controller can stall on the long operations.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4).
- CNTW, $clog2(WIDTH)+1, width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op are presented.
- in_ready  out  1  block can accept a new operation.
- op  in  4  operation code (see Behaviour).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result, hi, zero, ovf and err are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  primary result (low product / quotient).
- hi  out  WIDTH  high product / remainder; 0 for single-cycle ops.
- zero  out  1  result == 0.
- ovf  out  1  signed overflow (ADD/SUB only, else 0).
- err  out  1  illegal op, or DIVU with b == 0.

Behaviour:
- Op encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed).
  - 0011 XOR, 0100 NOR, 0101 SLTU.
  - 1000 MULU, 1010 DIVU.
  - All other codes are illegal.
- Reset (async assert, sync deassert by the system):
  - State IDLE; in_ready=1 while in IDLE.
  - out_valid=0; result, hi = 0; zero=1 (consistent with result == 0); ovf, err = 0.
  - Iteration counter = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Accept occurs on in_valid && in_ready. a, b and op are captured on the same edge.
  - Single-cycle ops and illegal ops go to DONE; the result is computed from the captured inputs and registered on the accepting edge. out_valid is high the next cycle (latency 1).
  - MULU and DIVU go to BUSY with the counter loaded to WIDTH.
- BUSY:
  - One shift-add (MULU) or restoring-subtract (DIVU) step per cycle; counter decrements.
  - When the counter reaches 1, the final step is taken and the FSM moves to DONE. out_valid rises WIDTH+1 cycles after the accept edge (33 for WIDTH=32).
  - in_ready=0 throughout BUSY.
- DONE:
  - out_valid=1; all outputs are held stable until out_valid && out_ready, then the FSM returns to IDLE.
  - in_ready=0 in DONE, so there is no back-to-back overlap; maximum throughput is 1 op per 2 cycles.
- Arithmetic:
  - SUB = a + ~b + 1.
  - SLT = sign of (a − b) XOR signed overflow, zero-extended to WIDTH. This corrects the overflow case (e.g. a = 0x8000_0000, b = 1).
  - SLTU = borrow out of a − b.
  - ovf = carry-in to the MSB XOR carry-out of the MSB (ADD/SUB).
  - MULU: {hi, result} is the full 2·WIDTH-bit unsigned product.
  - DIVU: result = quotient, hi = remainder.
- Boundary conditions:
  - DIVU with b=0: still takes WIDTH+1 cycles; result = all ones, hi = a, err = 1.
  - Illegal op: result = 0, hi = 0, zero = 1, err = 1, latency 1.
  - in_valid while not ready is ignored. The source must hold its inputs; the block never captures them.
  - Reset mid-BUSY or in DONE: the operation is abandoned and all outputs return to reset values immediately.
  - out_ready high while out_valid is low has no effect.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: DIVU is implemented as above.
- Undefined: no divider hardware; 1010 is treated as an illegal op (latency 1, err = 1, result = hi = 0). MULU is unaffected.

Decomposition:
- Package alu_seq_pkg holds:
  - The op code localparams: OP_AND, OP_OR, OP_ADD, OP_XOR, OP_NOR, OP_SLTU, OP_SUB, OP_SLT, OP_MULU, OP_DIVU.
  - The FSM state typedef/encoding.
  - A function is_multicycle(op).
- One natural sub-module: alu_seq_muldiv. It holds the shared WIDTH-iteration shift register, counter and add/subtract step, with start/done inputs and outputs. alu_seq owns the FSM, the single-cycle logic and the output registers.

Test Plan:
1. Reset, then ADD a=0x7FFF_FFFF, b=1 → out_valid next cycle, result=0x8000_0000, ovf=1, zero=0, hi=0.
2. SUB a=5, b=5 → result=0, zero=1, ovf=0. SLT a=0x8000_0000, b=1 → result=1. SLTU with the same operands → result=0.
3. MULU a=0xFFFF_FFFF, b=0xFFFF_FFFF → out_valid exactly 33 cycles after accept; hi=0xFFFF_FFFE, result=0x0000_0001. in_ready low throughout.
4. DIVU a=100, b=7 → result=14, hi=2. DIVU a=9, b=0 → result=0xFFFF_FFFF, hi=9, err=1. With ALU_SEQ_DIV_EN undefined → err=1 after 1 cycle, result=0.
5. Backpressure: hold out_ready=0 for 5 cycles after an OR op. Outputs stay stable, in_ready stays 0, a new in_valid is ignored. Releasing out_ready returns to IDLE and the next op is accepted.
6. Assert reset_n=0 at cycle 10 of a MULU → out_valid=0 and in_ready=1 without waiting for a clock edge. The next op (op=1111) → err=1, zero=1.
